// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared widths, opcodes, operand addresses and FSM encoding for the UART command sequencer.
package uart_cmd_ctrl_pkg;

    localparam int WIDTH         = 8;
    localparam int ADDR_WIDTH    = 4;
    localparam int ALU_OUT_WIDTH = 16;
    localparam int FUN_WIDTH     = 4;

    localparam logic [WIDTH-1:0] CMD_WR      = 8'hAA;
    localparam logic [WIDTH-1:0] CMD_RD      = 8'hBB;
    localparam logic [WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = 4'd0;
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = 4'd1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        ALU_FUN  = 4'd7,
        ALU_WAIT = 4'd8,
        TX_LO    = 4'd9,
        TX_HI    = 4'd10
    } state_t;

    // States in which an incoming RX byte cannot be consumed and is dropped.
    function automatic logic rx_blocked(input state_t st);
        return (st == RD_WAIT) || (st == ALU_WAIT) || (st == TX_LO) || (st == TX_HI);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of RX, register-file, ALU and TX signals around the command sequencer.
interface uart_cmd_ctrl_if;
    import uart_cmd_ctrl_pkg::*;

    logic [WIDTH-1:0]         i_rx_data;
    logic                     i_rx_valid;
    logic                     o_rf_wr_en;
    logic                     o_rf_rd_en;
    logic [ADDR_WIDTH-1:0]    o_rf_addr;
    logic [WIDTH-1:0]         o_rf_wr_data;
    logic [WIDTH-1:0]         i_rf_rd_data;
    logic                     i_rf_rd_valid;
    logic                     o_alu_en;
    logic [FUN_WIDTH-1:0]     o_alu_fun;
    logic [ALU_OUT_WIDTH-1:0] i_alu_out;
    logic                     i_alu_valid;
    logic [WIDTH-1:0]         o_tx_data;
    logic                     o_tx_valid;
    logic                     i_tx_ready;
    logic                     o_cmd_err;
    logic                     o_overrun;

    modport master (
        input  i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
               i_alu_out, i_alu_valid, i_tx_ready,
        output o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data,
               o_alu_en, o_alu_fun, o_tx_data, o_tx_valid, o_cmd_err, o_overrun
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
               i_alu_out, i_alu_valid, i_tx_ready,
        input  o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data,
               o_alu_en, o_alu_fun, o_tx_data, o_tx_valid, o_cmd_err, o_overrun
    );

endinterface

// File: rtl/uart_cmd_tx_serializer.sv
// Sends a 1- or 2-byte payload LSB first over a valid/ready handshake.
module uart_cmd_tx_serializer
    import uart_cmd_ctrl_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  logic [ALU_OUT_WIDTH-1:0] i_payload,
    input  logic                     i_two_bytes,
    input  logic                     i_tx_ready,
    output logic [WIDTH-1:0]         o_tx_data,
    output logic                     o_tx_valid,
    output logic                     o_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             more_q, more_d;

    assign o_accept   = valid_q & i_tx_ready;
    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        hi_d    = hi_q;
        more_d  = more_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_payload[WIDTH-1:0];
            hi_d    = i_payload[ALU_OUT_WIDTH-1:WIDTH];
            more_d  = i_two_bytes;
        end else if (o_accept) begin
            // Data only changes on a transfer, so it is stable while valid waits for ready.
            if (more_q) begin
                data_d = hi_q;
                more_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hi_q    <= '0;
            more_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            more_q  <= more_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses RX frames into register-file and ALU operations
// and returns read/ALU results to the transmitter.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
(
    input logic             i_clk,
    input logic             i_rst,
    uart_cmd_ctrl_if.master bus
);

    // state    | meaning
    // IDLE     | waiting for an opcode byte
    // WR_ADDR  | write frame, expecting address byte
    // WR_DATA  | write frame, expecting data byte
    // RD_ADDR  | read frame, expecting address byte
    // RD_WAIT  | waiting for register-file read data
    // OP_A     | ALU frame, expecting operand A (goes to OPA_ADDR)
    // OP_B     | ALU frame, expecting operand B (goes to OPB_ADDR)
    // ALU_FUN  | expecting ALU function byte
    // ALU_WAIT | waiting for ALU result
    // TX_LO    | sending result low byte
    // TX_HI    | sending last byte (result high byte or read data)

    state_t                   state_q, state_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic                     cmd_err_q, cmd_err_d;
    logic                     overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]         wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]     fun_q, fun_d;

    logic                     ser_load;
    logic [ALU_OUT_WIDTH-1:0] ser_payload;
    logic                     ser_two;
    logic                     tx_accept;

    uart_cmd_tx_serializer u_tx_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (ser_load),
        .i_payload   (ser_payload),
        .i_two_bytes (ser_two),
        .i_tx_ready  (bus.i_tx_ready),
        .o_tx_data   (bus.o_tx_data),
        .o_tx_valid  (bus.o_tx_valid),
        .o_accept    (tx_accept)
    );

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        cmd_err_d   = 1'b0;
        overrun_d   = bus.i_rx_valid & rx_blocked(state_q);
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        fun_d       = fun_q;
        ser_load    = 1'b0;
        ser_payload = '0;
        ser_two     = 1'b0;

        case (state_q)
            IDLE: if (bus.i_rx_valid) begin
                case (bus.i_rx_data)
                    CMD_WR:      state_d = WR_ADDR;
                    CMD_RD:      state_d = RD_ADDR;
                    CMD_ALU_OP:  state_d = OP_A;
                    CMD_ALU_NOP: state_d = ALU_FUN;
                    default:     cmd_err_d = 1'b1;
                endcase
            end
            WR_ADDR: if (bus.i_rx_valid) begin
                addr_d  = bus.i_rx_data[ADDR_WIDTH-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (bus.i_rx_valid) begin
                wr_data_d = bus.i_rx_data;
                wr_en_d   = 1'b1;
                state_d   = IDLE;
            end
            RD_ADDR: if (bus.i_rx_valid) begin
                addr_d  = bus.i_rx_data[ADDR_WIDTH-1:0];
                rd_en_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (bus.i_rf_rd_valid) begin
                ser_load    = 1'b1;
                ser_payload = {{(ALU_OUT_WIDTH-WIDTH){1'b0}}, bus.i_rf_rd_data};
                state_d     = TX_HI;
            end
            OP_A: if (bus.i_rx_valid) begin
                addr_d    = OPA_ADDR;
                wr_data_d = bus.i_rx_data;
                wr_en_d   = 1'b1;
                state_d   = OP_B;
            end
            OP_B: if (bus.i_rx_valid) begin
                addr_d    = OPB_ADDR;
                wr_data_d = bus.i_rx_data;
                wr_en_d   = 1'b1;
                state_d   = ALU_FUN;
            end
            ALU_FUN: if (bus.i_rx_valid) begin
                fun_d    = bus.i_rx_data[FUN_WIDTH-1:0];
                alu_en_d = 1'b1;
                state_d  = ALU_WAIT;
            end
            ALU_WAIT: if (bus.i_alu_valid) begin
                ser_load    = 1'b1;
                ser_payload = bus.i_alu_out;
                ser_two     = 1'b1;
                state_d     = TX_LO;
            end
            TX_LO: if (tx_accept) state_d = TX_HI;
            TX_HI: if (tx_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            overrun_q <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            fun_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            cmd_err_q <= cmd_err_d;
            overrun_q <= overrun_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            fun_q     <= fun_d;
        end
    end

    assign bus.o_rf_wr_en   = wr_en_q;
    assign bus.o_rf_rd_en   = rd_en_q;
    assign bus.o_rf_addr    = addr_q;
    assign bus.o_rf_wr_data = wr_data_q;
    assign bus.o_alu_en     = alu_en_q;
    assign bus.o_alu_fun    = fun_q;
    assign bus.o_cmd_err    = cmd_err_q;
    assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Transaction-level bench for uart_cmd_ctrl: frames are turned into expected strobe/TX events.
module tb_uart_cmd_ctrl;
    import uart_cmd_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   hold_ready = 1'b0;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic [3:0] val; int cyc; } ev_t;

    wr_t        exp_wr[$];
    ev_t        exp_rd[$];
    ev_t        exp_alu[$];
    int         exp_err[$];
    int         exp_ovr[$];
    int         exp_rise[$];
    logic [7:0] exp_tx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return {2'b00, bus.o_rf_wr_en, bus.o_rf_rd_en, bus.o_rf_addr, bus.o_rf_wr_data,
                bus.o_alu_en, bus.o_alu_fun, bus.o_tx_data, bus.o_tx_valid,
                bus.o_cmd_err, bus.o_overrun};
    endfunction

    // Expected strobes land one cycle after the byte/pulse driven now.
    function automatic void push_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = cyc + 1;
        exp_wr.push_back(w);
    endfunction

    function automatic void push_ev(input bit is_alu, input logic [3:0] v);
        ev_t e;
        e.val = v; e.cyc = cyc + 1;
        if (is_alu) exp_alu.push_back(e);
        else exp_rd.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        bus.i_rx_valid    = 1'b0;
        bus.i_rf_rd_valid = 1'b0;
        bus.i_alu_valid   = 1'b0;
        bus.i_tx_ready    = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic inject_overrun(input logic [7:0] b);
        exp_ovr.push_back(cyc + 1);
        send_byte(b);
    endtask

    task automatic wait_phase(input int n);
        repeat (n) begin
            if ($urandom_range(0, 3) == 0) inject_overrun(8'($urandom_range(0, 255)));
            else tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_tx.size() != 0 && n < 300) begin
            if ($urandom_range(0, 5) == 0) inject_overrun(8'($urandom_range(0, 255)));
            else tick();
            n++;
        end
        if (exp_tx.size() != 0) begin
            check("tx_drain_timeout", exp_tx.size(), 0);
            exp_tx.delete();
        end
    endtask

    task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
        send_byte(CMD_WR); gap();
        send_byte(a); gap();
        push_wr(a[3:0], d);
        send_byte(d);
    endtask

    task automatic frame_rd(input logic [7:0] a, input logic [7:0] d);
        send_byte(CMD_RD); gap();
        push_ev(1'b0, a[3:0]);
        send_byte(a);
        wait_phase($urandom_range(0, 3));
        exp_tx.push_back(d);
        exp_rise.push_back(cyc + 1);
        bus.i_rf_rd_data  = d;
        bus.i_rf_rd_valid = 1'b1;
        tick();
        drain();
    endtask

    task automatic respond_alu(input logic [15:0] r);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        exp_rise.push_back(cyc + 1);
        bus.i_alu_out   = r;
        bus.i_alu_valid = 1'b1;
        tick();
    endtask

    task automatic frame_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input logic [15:0] r, input bit hold);
        if (with_ops) begin
            send_byte(CMD_ALU_OP); gap();
            push_wr(4'd0, a); send_byte(a); gap();
            push_wr(4'd1, b); send_byte(b); gap();
        end else begin
            send_byte(CMD_ALU_NOP); gap();
        end
        push_ev(1'b1, f[3:0]);
        send_byte(f);
        hold_ready = hold;
        wait_phase(hold ? 0 : $urandom_range(0, 3));
        respond_alu(r);
        if (hold) begin
            repeat (5) begin
                check("hold_valid", bus.o_tx_valid, 1'b1);
                check("hold_data", bus.o_tx_data, r[7:0]);
                tick();
            end
            hold_ready = 1'b0;
        end
        drain();
    endtask

    task automatic junk_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == CMD_WR || b == CMD_RD || b == CMD_ALU_OP || b == CMD_ALU_NOP);
        exp_err.push_back(cyc + 1);
        send_byte(b);
    endtask

    // Compare process: every strobe and TX transfer must match the next expected event.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_xfer  = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        wr_t        w;
        ev_t        e;
        int         c;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
            end else begin
                if (bus.o_rf_wr_en) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", bus.o_rf_addr, w.addr);
                        check("wr_data", bus.o_rf_wr_data, w.data);
                        check("wr_cycle", cyc, w.cyc);
                    end
                end
                if (bus.o_rf_rd_en) begin
                    if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        e = exp_rd.pop_front();
                        check("rd_addr", bus.o_rf_addr, e.val);
                        check("rd_cycle", cyc, e.cyc);
                    end
                end
                if (bus.o_alu_en) begin
                    if (exp_alu.size() == 0) check("alu_unexpected", 1, 0);
                    else begin
                        e = exp_alu.pop_front();
                        check("alu_fun", bus.o_alu_fun, e.val);
                        check("alu_cycle", cyc, e.cyc);
                    end
                end
                if (bus.o_cmd_err) begin
                    if (exp_err.size() == 0) check("err_unexpected", 1, 0);
                    else begin
                        c = exp_err.pop_front();
                        check("err_cycle", cyc, c);
                    end
                end
                if (bus.o_overrun) begin
                    if (exp_ovr.size() == 0) check("ovr_unexpected", 1, 0);
                    else begin
                        c = exp_ovr.pop_front();
                        check("ovr_cycle", cyc, c);
                    end
                end
                if (bus.o_tx_valid && !prev_valid) begin
                    if (exp_rise.size() == 0) check("tx_rise_unexpected", 1, 0);
                    else begin
                        c = exp_rise.pop_front();
                        check("tx_rise_cycle", cyc, c);
                    end
                end
                if (prev_valid && !prev_xfer) begin
                    check("tx_valid_stable", bus.o_tx_valid, 1'b1);
                    check("tx_data_stable", bus.o_tx_data, prev_data);
                end
                if (bus.o_tx_valid && bus.i_tx_ready) begin
                    if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                    else begin
                        t = exp_tx.pop_front();
                        check("tx_data", bus.o_tx_data, t);
                    end
                end
                prev_valid = bus.o_tx_valid;
                prev_data  = bus.o_tx_data;
                prev_xfer  = bus.o_tx_valid & bus.i_tx_ready;
            end
        end
    end

    initial begin
        bus.i_rx_data     = '0;
        bus.i_rx_valid    = 1'b0;
        bus.i_rf_rd_data  = '0;
        bus.i_rf_rd_valid = 1'b0;
        bus.i_alu_out     = '0;
        bus.i_alu_valid   = 1'b0;
        bus.i_tx_ready    = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_state", outs(), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        frame_wr(8'h05, 8'h3C);
        frame_rd(8'h05, 8'h3C);
        frame_alu(1'b1, 8'h0A, 8'h03, 8'h00, 16'h000D, 1'b1);

        junk_byte();
        send_byte(8'h55);
        exp_err.push_back(cyc);
        gap();
        frame_wr(8'h01, 8'hFF);

        send_byte(CMD_ALU_NOP);
        push_ev(1'b1, 4'h3);
        send_byte(8'h03);
        inject_overrun(8'h77);
        respond_alu(16'hBEEF);
        drain();

        frame_wr(8'hF7, 8'h5A);
        frame_alu(1'b0, 8'h00, 8'h00, 8'h3B, 16'h8001, 1'b0);

        send_byte(CMD_WR);
        send_byte(8'h02);
        rst = 1'b1;
        #1 check("reset_mid_frame", outs(), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        frame_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: frame_wr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                1: frame_rd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                2: frame_alu(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 1'b0);
                3: frame_alu(1'b0, 8'h00, 8'h00, 8'($urandom_range(0, 255)),
                             16'($urandom_range(0, 65535)), 1'b0);
                default: junk_byte();
            endcase
            gap();
        end

        repeat (3) tick();
        check("left_wr", exp_wr.size(), 0);
        check("left_rd", exp_rd.size(), 0);
        check("left_alu", exp_alu.size(), 0);
        check("left_err", exp_err.size(), 0);
        check("left_ovr", exp_ovr.size(), 0);
        check("left_rise", exp_rise.size(), 0);
        check("left_tx", exp_tx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receiver and the processing core. It consumes the receiver's byte/valid stream and parses command frames. It issues register-file writes/reads and ALU operations, then returns results byte-wise to the UART transmitter through a valid/ready handshake. It is the only master of the register file and ALU.

Parameters:
WIDTH, 8, UART byte / register data width
ADDR_WIDTH, 4, register-file address width
ALU_OUT_WIDTH, 16, ALU result width (two bytes returned, LSB first)
FUN_WIDTH, 4, ALU function code width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_rx_data  in  WIDTH  byte from UART RX
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
o_rf_wr_en  out  1  register-file write strobe (1 cycle)
o_rf_rd_en  out  1  register-file read strobe (1 cycle)
o_rf_addr  out  ADDR_WIDTH  register-file address
o_rf_wr_data  out  WIDTH  register-file write data
i_rf_rd_data  in  WIDTH  register-file read data
i_rf_rd_valid  in  1  read data valid pulse
o_alu_en  out  1  ALU start strobe (1 cycle)
o_alu_fun  out  FUN_WIDTH  ALU function code
i_alu_out  in  ALU_OUT_WIDTH  ALU result
i_alu_valid  in  1  ALU result valid pulse
o_tx_data  out  WIDTH  byte to UART TX
o_tx_valid  out  1  TX byte valid, held until accepted
i_tx_ready  in  1  TX can accept; transfer on valid && ready
o_cmd_err  out  1  one-cycle pulse: unknown opcode
o_overrun  out  1  one-cycle pulse: byte dropped while busy

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal address/result registers cleared. An async reset mid-frame aborts the frame with no partial write.
- Opcodes (first byte of frame): 0xAA write {addr, data}; 0xBB read {addr}; 0xCC ALU with operands {A, B, fun}; 0xDD ALU without operands {fun}.
- Only the low ADDR_WIDTH bits of address bytes are used. Only the low FUN_WIDTH bits of fun bytes are used.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on rx_valid:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUN.
  - Any other byte: pulse o_cmd_err, stay in IDLE.
- WR_ADDR: latch addr -> WR_DATA.
- WR_DATA: on byte, assert o_rf_wr_en for exactly 1 cycle in the cycle after rx_valid (addr, data stable that cycle) -> IDLE.
- RD_ADDR: on byte, pulse o_rf_rd_en with addr -> RD_WAIT.
- RD_WAIT: on i_rf_rd_valid, load o_tx_data = rd_data -> TX_HI (single-byte reply; TX_HI is the last-byte state).
- OP_A: byte is written to reg address 0 (one wr_en pulse) -> OP_B.
- OP_B: byte is written to reg address 1 (one wr_en pulse) -> ALU_FUN.
- ALU_FUN: latch fun, pulse o_alu_en for 1 cycle -> ALU_WAIT.
- ALU_WAIT: on i_alu_valid, capture i_alu_out -> TX_LO.
- TX_LO: o_tx_valid=1, o_tx_data=result[7:0]; on ready -> TX_HI with result[15:8].
- TX_HI: hold valid until ready -> IDLE; o_tx_valid drops the cycle after acceptance.
- o_tx_data is stable while o_tx_valid is high. Valid never drops without a transfer.
- An rx_valid in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: pulse o_overrun, drop the byte, state unchanged.
- An rx_valid in the same cycle as the tx acceptance in TX_HI: still an overrun. The byte is not treated as an opcode.
- Latency: 0xAA frame -> wr_en 1 cycle after the data byte's rx_valid. ALU result -> o_tx_valid 1 cycle after i_alu_valid.
- No timeout: an incomplete frame waits indefinitely.

Decomposition:
- Shared package/include holds:
  - opcode constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - the FSM state encoding;
  - operand register addresses OPA_ADDR=0, OPB_ADDR=1.
- One natural sub-module: uart_cmd_tx_serializer. It takes a 1- or 2-byte payload plus a byte count and runs the valid/ready handshake for TX_LO/TX_HI.

Test Plan:
1. Frame AA,05,3C -> single o_rf_wr_en pulse with addr=5, wr_data=0x3C; no tx activity.
2. Frame BB,05, then rf returns 0x3C -> exactly one tx transfer of 0x3C; FSM returns to IDLE.
3. Frame CC,0A,03,00 with ALU out=0x000D -> writes 0x0A@0 and 0x03@1, alu_en with fun=0, then tx bytes 0x0D then 0x00, LSB first. Hold i_tx_ready low 5 cycles: data and valid must stay stable.
4. Byte 0x55 in IDLE -> o_cmd_err pulse. A following AA,01,FF must still write 0xFF@1.
5. Byte 0x77 arrives during ALU_WAIT -> o_overrun pulse, byte dropped, correct 2-byte result still sent.
6. Assert i_rst after AA,02 (before the data byte) -> all outputs 0 immediately and no write. A following DD,02 sends an ALU op with fun=2.
